// File: rtl/pong_ball.sv
`default_nettype none
// ============================================================================
// pong_ball : tick-driven ball motion with wall/paddle reflection and miss detection
// Rev 1.0
// ============================================================================
module pong_ball #(
  parameter int FIELD_W    = 640,
  parameter int FIELD_H    = 480,
  parameter int BALL       = 8,
  parameter int STEP       = 1,
  parameter int PADDLE_H   = 64,
  parameter int PADDLE_W   = 8,
  parameter int PADDLE_XL  = 16,
  parameter int PADDLE_XR  = 616,
  parameter int HOLD_TICKS = 60,
  parameter int W          = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         serve,
  input  logic [W-1:0] paddle_l_y,
  input  logic [W-1:0] paddle_r_y,
  output logic [W-1:0] ball_x,
  output logic [W-1:0] ball_y,
  output logic         in_play,
  output logic         score_l,
  output logic         score_r
);

  localparam int XW = W + 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [W:0] C_CX    = XW'((FIELD_W - BALL) / 2);
  localparam logic [W:0] C_CY    = XW'((FIELD_H - BALL) / 2);
  localparam logic [W:0] C_XMAX  = XW'(FIELD_W - BALL);
  localparam logic [W:0] C_YMAX  = XW'(FIELD_H - BALL);
  localparam logic [W:0] C_LFACE = XW'(PADDLE_XL + PADDLE_W);
  localparam logic [W:0] C_RFACE = XW'(PADDLE_XR - BALL);
  localparam logic [W:0] C_STEP  = XW'(STEP);
  localparam logic [W:0] C_BALL  = XW'(BALL);
  localparam logic [W:0] C_PH    = XW'(PADDLE_H);
  localparam logic [HW-1:0] C_HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE   = 2'd1,
    S_SCORED = 2'd2
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_y;
  logic          r_dx_right;
  logic          r_dy_down;
  logic [HW-1:0] r_hold;
  logic          r_score_l;
  logic          r_score_r;

  logic [W:0]    w_x;
  logic [W:0]    w_y;
  logic [W:0]    w_pl;
  logic [W:0]    w_pr;
  logic          w_ovl;
  logic          w_ovr;
  logic [W-1:0]  w_y_nx;
  logic          w_dy_nx;
  logic [W-1:0]  w_x_nx;
  logic          w_dx_nx;
  logic          w_miss;

  assign w_x  = {1'b0, r_x};
  assign w_y  = {1'b0, r_y};
  assign w_pl = {1'b0, paddle_l_y};
  assign w_pr = {1'b0, paddle_r_y};

  assign w_ovl = (w_y + C_BALL > w_pl) && (w_y < w_pl + C_PH);
  assign w_ovr = (w_y + C_BALL > w_pr) && (w_y < w_pr + C_PH);

  always_comb begin
    w_y_nx  = r_y;
    w_dy_nx = r_dy_down;
    if (r_dy_down) begin
      if (w_y + C_STEP >= C_YMAX) begin
        w_y_nx  = W'(C_YMAX);
        w_dy_nx = 1'b0;
      end else begin
        w_y_nx = W'(w_y + C_STEP);
      end
    end else if (w_y <= C_STEP) begin
      w_y_nx  = '0;
      w_dy_nx = 1'b1;
    end else begin
      w_y_nx = W'(w_y - C_STEP);
    end
  end

  // A miss leaves x frozen and re-aims the next serve back the way the ball came.
  always_comb begin
    w_x_nx  = r_x;
    w_dx_nx = r_dx_right;
    w_miss  = 1'b0;
    if (r_dx_right) begin
      if ((w_x <= C_RFACE) && (w_x + C_STEP >= C_RFACE) && w_ovr) begin
        w_x_nx  = W'(C_RFACE);
        w_dx_nx = 1'b0;
      end else if (w_x + C_STEP > C_XMAX) begin
        w_miss  = 1'b1;
        w_dx_nx = 1'b0;
      end else begin
        w_x_nx = W'(w_x + C_STEP);
      end
    end else begin
      if ((w_x >= C_LFACE) && (w_x <= C_LFACE + C_STEP) && w_ovl) begin
        w_x_nx  = W'(C_LFACE);
        w_dx_nx = 1'b1;
      end else if (w_x < C_STEP) begin
        w_miss  = 1'b1;
        w_dx_nx = 1'b1;
      end else begin
        w_x_nx = W'(w_x - C_STEP);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_x        <= W'(C_CX);
      r_y        <= W'(C_CY);
      r_dx_right <= 1'b1;
      r_dy_down  <= 1'b1;
      r_hold     <= '0;
      r_score_l  <= 1'b0;
      r_score_r  <= 1'b0;
    end else begin
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (serve) r_state <= S_MOVE;
        end
        S_MOVE: begin
          if (tick) begin
            r_y        <= w_y_nx;
            r_dy_down  <= w_dy_nx;
            r_x        <= w_x_nx;
            r_dx_right <= w_dx_nx;
            if (w_miss) begin
              r_state   <= S_SCORED;
              r_hold    <= '0;
              r_score_l <= r_dx_right;
              r_score_r <= ~r_dx_right;
            end
          end
        end
        S_SCORED: begin
          if (tick) begin
            if (r_hold == C_HOLD_LAST) begin
              r_state <= S_IDLE;
              r_hold  <= '0;
              r_x     <= W'(C_CX);
              r_y     <= W'(C_CY);
            end else begin
              r_hold <= r_hold + HW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ball_x  = r_x;
  assign ball_y  = r_y;
  assign in_play = (r_state == S_MOVE);
  assign score_l = r_score_l;
  assign score_r = r_score_r;

endmodule
`default_nettype wire

// File: tb/tb_pong_ball.sv
`default_nettype none
// ============================================================================
// tb_pong_ball : directed vector table, corner sequences and randomized play vs a reference model
// Rev 1.0
// ============================================================================
module tb_pong_ball;

  localparam int FIELD_W = 640, FIELD_H = 480, BALL = 8, STEP = 1;
  localparam int PADDLE_H = 64, PADDLE_W = 8, PADDLE_XL = 16, PADDLE_XR = 616;
  localparam int HOLD = 60;
  localparam int CX = (FIELD_W - BALL) / 2, CY = (FIELD_H - BALL) / 2;
  localparam int XMAX = FIELD_W - BALL, YMAX = FIELD_H - BALL;
  localparam int LFACE = PADDLE_XL + PADDLE_W, RFACE = PADDLE_XR - BALL;

  logic       clk, reset, tick, serve;
  logic [9:0] paddle_l_y, paddle_r_y;
  logic [9:0] ball_x, ball_y;
  logic       in_play, score_l, score_r;

  pong_ball dut (
    .clk(clk), .reset(reset), .tick(tick), .serve(serve),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .ball_x(ball_x), .ball_y(ball_y), .in_play(in_play),
    .score_l(score_l), .score_r(score_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: signed velocities, mode 0=idle 1=moving 2=frozen after a score
  int m_x, m_y, m_vx, m_vy, m_mode, m_hold;
  bit m_sl, m_sr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = CX; m_y = CY; m_vx = 1; m_vy = 1; m_mode = 0; m_hold = 0;
    m_sl = 0; m_sr = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input int pl, input int pr);
    int  ny, nvy;
    bit  hit_l, hit_r;
    m_sl = 0; m_sr = 0;
    if (m_mode == 0) begin
      if (s) m_mode = 1;
    end else if (m_mode == 1) begin
      if (t) begin
        hit_l = (m_y + BALL > pl) && (m_y < pl + PADDLE_H);
        hit_r = (m_y + BALL > pr) && (m_y < pr + PADDLE_H);
        nvy = m_vy;
        ny  = m_y + m_vy * STEP;
        if (m_vy > 0 && ny >= YMAX) begin ny = YMAX; nvy = -1; end
        else if (m_vy < 0 && m_y <= STEP) begin ny = 0; nvy = 1; end
        if (m_vx > 0) begin
          if (m_x <= RFACE && m_x + STEP >= RFACE && hit_r) begin m_x = RFACE; m_vx = -1; end
          else if (m_x + STEP > XMAX) begin m_sl = 1; m_mode = 2; m_hold = 0; m_vx = -1; end
          else m_x = m_x + STEP;
        end else begin
          if (m_x >= LFACE && m_x - STEP <= LFACE && hit_l) begin m_x = LFACE; m_vx = 1; end
          else if (m_x < STEP) begin m_sr = 1; m_mode = 2; m_hold = 0; m_vx = 1; end
          else m_x = m_x - STEP;
        end
        m_y = ny; m_vy = nvy;
      end
    end else begin
      if (t) begin
        m_hold++;
        if (m_hold == HOLD) begin m_mode = 0; m_x = CX; m_y = CY; end
      end
    end
  endtask

  task automatic check_model();
    check("model_x", 32'(ball_x), 32'(m_x));
    check("model_y", 32'(ball_y), 32'(m_y));
    check("model_in_play", 32'(in_play), 32'(m_mode == 1));
    check("model_score_l", 32'(score_l), 32'(m_sl));
    check("model_score_r", 32'(score_r), 32'(m_sr));
  endtask

  task automatic cyc(input bit t, input bit s);
    tick = t; serve = s;
    @(posedge clk);
    model_step(t, s, int'(paddle_l_y), int'(paddle_r_y));
    #1;
    tick = 1'b0; serve = 1'b0;
    check_model();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, 32'(ball_x), CX);
    check({tag, "_y"}, 32'(ball_y), CY);
    check({tag, "_in_play"}, 32'(in_play), 0);
    check({tag, "_score_l"}, 32'(score_l), 0);
    check({tag, "_score_r"}, 32'(score_r), 0);
  endtask

  // Reset asserted mid-cycle, well away from any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals(tag);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [9:0] pick_pad();
    int v;
    if ($urandom_range(0, 9) == 0) v = int'($urandom_range(0, 1023));
    else begin
      v = m_y + BALL - int'($urandom_range(0, 75));
      if (v < 0) v = 0;
    end
    return 10'(v);
  endfunction

  typedef struct {
    bit         tk;
    bit         sv;
    logic [9:0] pr;
    int         n;
    int         ex;
    int         ey;
    bit         ep;
  } vec_t;

  vec_t tv[6];
  int   sp_x[2][4];
  int   sp_y[2][4];

  task automatic spacing_run(input int idx, input int gap);
    async_reset("sp_rst");
    paddle_l_y = 10'd0; paddle_r_y = 10'd400;
    cyc(0, 1);
    for (int k = 0; k < 4; k++) begin
      repeat (gap) cyc(0, 0);
      cyc(1, 0);
      sp_x[idx][k] = int'(ball_x);
      sp_y[idx][k] = int'(ball_y);
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; serve = 1'b0;
    paddle_l_y = 10'd0; paddle_r_y = 10'd400;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // Serve (with a simultaneous tick that must not move), then a long rally to the right paddle.
    tv[0] = '{1, 1, 10'd400,   1, 316, 236, 1};
    tv[1] = '{1, 0, 10'd400,   1, 317, 237, 1};
    tv[2] = '{1, 0, 10'd400, 235, 552, 472, 1};
    tv[3] = '{1, 0, 10'd400,   1, 553, 471, 1};
    tv[4] = '{1, 0, 10'd400,  55, 608, 416, 1};
    tv[5] = '{1, 0, 10'd400,   1, 607, 415, 1};
    for (int i = 0; i < 6; i++) begin
      paddle_r_y = tv[i].pr;
      for (int n = 0; n < tv[i].n; n++) cyc(tv[i].tk, tv[i].sv);
      check($sformatf("vec%0d_x", i), 32'(ball_x), tv[i].ex);
      check($sformatf("vec%0d_y", i), 32'(ball_y), tv[i].ey);
      check($sformatf("vec%0d_in_play", i), 32'(in_play), 32'(tv[i].ep));
      check($sformatf("vec%0d_score_l", i), 32'(score_l), 0);
    end

    // Right-side miss, hold period, ignored serve, and re-serve to the left.
    async_reset("miss_rst");
    paddle_l_y = 10'd0; paddle_r_y = 10'd0;
    cyc(0, 1);
    repeat (316) cyc(1, 0);
    check("edge_x", 32'(ball_x), 632);
    check("edge_y", 32'(ball_y), 392);
    cyc(1, 0);
    check("miss_score_l", 32'(score_l), 1);
    check("miss_score_r", 32'(score_r), 0);
    check("miss_in_play", 32'(in_play), 0);
    cyc(0, 1);
    check("pulse_width", 32'(score_l), 0);
    check("serve_in_scored", 32'(in_play), 0);
    repeat (59) cyc(1, 0);
    check("hold_x", 32'(ball_x), 632);
    check("hold_y", 32'(ball_y), 391);
    cyc(1, 0);
    check("rehome_x", 32'(ball_x), CX);
    check("rehome_y", 32'(ball_y), CY);
    check("rehome_in_play", 32'(in_play), 0);
    cyc(0, 1);
    cyc(1, 0);
    check("reserve_x", 32'(ball_x), 315);
    check("reserve_y", 32'(ball_y), 235);

    // Reset mid-flight, and reset while a score pulse is pending.
    async_reset("flight_rst0");
    paddle_r_y = 10'd0;
    cyc(0, 1);
    repeat (84) cyc(1, 0);
    check("flight_x", 32'(ball_x), 400);
    async_reset("flight_rst");
    cyc(0, 1);
    repeat (317) cyc(1, 0);
    check("pending_score_l", 32'(score_l), 1);
    async_reset("pulse_rst");

    // Identical per-tick positions regardless of tick spacing.
    spacing_run(0, 0);
    spacing_run(1, 11999);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("spacing_x%0d", k), 32'(sp_x[1][k]), 32'(sp_x[0][k]));
      check($sformatf("spacing_y%0d", k), 32'(sp_y[1][k]), 32'(sp_y[0][k]));
      check($sformatf("spacing_abs_x%0d", k), 32'(sp_x[0][k]), 32'(317 + k));
    end

    // Randomized play: paddles mostly shadow the ball, sometimes wander off-field.
    async_reset("rand_rst");
    for (int i = 0; i < 20000; i++) begin
      paddle_l_y = pick_pad();
      paddle_r_y = pick_pad();
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
